// File: rtl/mem_pkg.sv
// Shared types and helpers for the wait-state memory model.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_state_t;

  // Wait-state counter width; covers the largest reload value, LATENCY-2 = 13.
  localparam int LAT_CNT_W = 4;

  // Byte-offset bits inside one data word: log2(data_w/8).
  function automatic int mem_ofs(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/mem_array.sv
// Byte-lane word RAM with a single synchronous read/write port and no reset.
// The array is named mem so benches can preload it through the hierarchy.
module mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8192,
  parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk,
  input  logic                en,
  input  logic                we,
  input  logic [IDX_W-1:0]    idx,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Read-before-write: rdata captures the old word while the enabled lanes update.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[idx];
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (we && wstrb[b]) begin
          mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/mem_wait.sv
// Memory model with configurable wait states, byte strobes and error reporting.
// A request latched on accept is committed to the array on the edge that raises
// mem_data_ready; a new request may be accepted on that same edge.
module mem_wait
  import mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 8192,
  parameter int LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_write,
  input  logic                mem_addr_ready,
  output logic                mem_busy,
  output logic                mem_data_ready,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_err
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFS   = mem_ofs(DATA_W);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] ALIGN_MASK = 32'(BYTES - 1);
  localparam logic [LAT_CNT_W-1:0] CNT_RELOAD =
    (LATENCY > 1) ? LAT_CNT_W'(LATENCY - 2) : '0;

  mem_state_t           state;
  logic [LAT_CNT_W-1:0] cnt;
  logic                 busy_q;
  logic                 dready_q;
  logic                 err_q;

  logic [31:0]          addr_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [BYTES-1:0]     wstrb_q;
  logic                 write_q;

  logic                 accept;
  logic [31:0]          word_idx;
  logic                 req_err;
  logic [IDX_W-1:0]     arr_idx;
  logic                 arr_en;
  logic                 arr_we;
  logic [DATA_W-1:0]    arr_rdata;

  assign accept   = mem_addr_ready && !busy_q;

  assign word_idx = addr_q >> OFS;
  assign req_err  = ((addr_q & ALIGN_MASK) != '0) || (word_idx >= 32'(DEPTH));
  assign arr_idx  = req_err ? '0 : word_idx[IDX_W-1:0];
  assign arr_en   = (state == RESP);
  assign arr_we   = arr_en && write_q && !req_err;

  assign mem_busy       = busy_q;
  assign mem_data_ready = dready_q;
  assign mem_err        = err_q;
  assign mem_rdata      = (dready_q && !err_q) ? arr_rdata : '0;

  // Request latch: captured on accept so the requester may move on afterwards.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
      wstrb_q <= mem_wstrb;
      write_q <= mem_write;
    end
  end

  // Control FSM: the edge leaving RESP commits the array and raises the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      busy_q   <= 1'b0;
      dready_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      dready_q <= (state == RESP);
      err_q    <= (state == RESP) && req_err;
      case (state)
        IDLE, RESP: begin
          if (accept) begin
            if (LATENCY == 1) begin
              state  <= RESP;
              busy_q <= 1'b0;
            end else begin
              state  <= WAIT;
              cnt    <= CNT_RELOAD;
              busy_q <= 1'b1;
            end
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state  <= RESP;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) mem_array (
    .clk   (clk),
    .en    (arr_en),
    .we    (arr_we),
    .idx   (arr_idx),
    .wstrb (wstrb_q),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_mem_wait.sv
// Directed bench for mem_wait across four configurations:
// u0 32b/L1, u1 32b/L4, u2 32b/L8 (own reset), u3 64b/L2; all DEPTH 64.
module tb_mem_wait;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rst2_n;
  logic [31:0] addr;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        write;
  logic [3:0]  ar;
  logic [3:0]  busy;
  logic [3:0]  dr;
  logic [3:0]  err;
  logic [31:0] rd0, rd1, rd2;
  logic [63:0] rd3;

  int n_checks = 0;
  int n_fail   = 0;
  logic busy_seen0 = 1'b0;

  always #5 clk = ~clk;

  always @(negedge clk) if (busy[0] === 1'b1) busy_seen0 <= 1'b1;

  mem_wait #(.DATA_W(32), .DEPTH(64), .LATENCY(1)) u0 (
    .clk(clk), .rst_n(rst_n), .mem_addr(addr), .mem_wdata(wdata[31:0]),
    .mem_wstrb(wstrb[3:0]), .mem_write(write), .mem_addr_ready(ar[0]),
    .mem_busy(busy[0]), .mem_data_ready(dr[0]), .mem_rdata(rd0), .mem_err(err[0]));

  mem_wait #(.DATA_W(32), .DEPTH(64), .LATENCY(4)) u1 (
    .clk(clk), .rst_n(rst_n), .mem_addr(addr), .mem_wdata(wdata[31:0]),
    .mem_wstrb(wstrb[3:0]), .mem_write(write), .mem_addr_ready(ar[1]),
    .mem_busy(busy[1]), .mem_data_ready(dr[1]), .mem_rdata(rd1), .mem_err(err[1]));

  mem_wait #(.DATA_W(32), .DEPTH(64), .LATENCY(8)) u2 (
    .clk(clk), .rst_n(rst_n & rst2_n), .mem_addr(addr), .mem_wdata(wdata[31:0]),
    .mem_wstrb(wstrb[3:0]), .mem_write(write), .mem_addr_ready(ar[2]),
    .mem_busy(busy[2]), .mem_data_ready(dr[2]), .mem_rdata(rd2), .mem_err(err[2]));

  mem_wait #(.DATA_W(64), .DEPTH(64), .LATENCY(2)) u3 (
    .clk(clk), .rst_n(rst_n), .mem_addr(addr), .mem_wdata(wdata),
    .mem_wstrb(wstrb), .mem_write(write), .mem_addr_ready(ar[3]),
    .mem_busy(busy[3]), .mem_data_ready(dr[3]), .mem_rdata(rd3), .mem_err(err[3]));

  function automatic logic [63:0] get_rd(input int u);
    case (u)
      0:       return {32'h0, rd0};
      1:       return {32'h0, rd1};
      2:       return {32'h0, rd2};
      default: return rd3;
    endcase
  endfunction

  // One request on instance u; returns response data, error and observed latency (-1 on timeout).
  task automatic xact(input int u, input logic [31:0] a, input logic [63:0] wd,
                      input logic [7:0] ws, input logic wr,
                      output logic [63:0] rdo, output logic ero, output int lat);
    @(negedge clk);
    addr = a; wdata = wd; wstrb = ws; write = wr; ar[u] = 1'b1;
    for (int k = 0; k < 40 && busy[u] === 1'b1; k++) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    ar[u] = 1'b0;
    lat = -1; rdo = '0; ero = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (dr[u] === 1'b1) begin
        lat = k; rdo = get_rd(u); ero = err[u];
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst2_n = 1'b1; ar = '0;
    addr = '0; wdata = '0; wstrb = '0; write = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({dr, busy, err} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_ctrl: dr/busy/err=%h required 000", {dr, busy, err});
    end
    for (int u = 0; u < 4; u++) begin
      n_checks++;
      if (get_rd(u) !== 64'h0) begin
        n_fail++;
        $display("FAIL reset_rdata u%0d: got %h required 0", u, get_rd(u));
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_preload();
    logic [63:0] r; logic e; int lat;
    u0.mem_array.mem[0] = 32'h11223344;
    xact(0, 32'h0, 64'h0, 8'h0, 1'b0, r, e, lat);
    n_checks++;
    if (lat !== 1 || r !== 64'h11223344 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL preload_read: lat=%0d rdata=%h err=%b required lat=1 rdata=11223344 err=0", lat, r, e);
    end
  endtask

  task automatic test_strobe();
    logic [63:0] r; logic e; int lat;
    u0.mem_array.mem[1] = 32'h00000000;
    xact(0, 32'h4, 64'hAABBCCDD, 8'h05, 1'b1, r, e, lat);
    n_checks++;
    if (lat !== 1 || r !== 64'h0 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL strobe_write_resp: lat=%0d rdata=%h err=%b required lat=1 rdata=0 err=0", lat, r, e);
    end
    xact(0, 32'h4, 64'h0, 8'h0, 1'b0, r, e, lat);
    n_checks++;
    if (r !== 64'h00BB00DD || e !== 1'b0) begin
      n_fail++;
      $display("FAIL strobe_readback: rdata=%h err=%b required 00BB00DD err=0", r, e);
    end
  endtask

  task automatic test_wait_states();
    u1.mem_array.mem[3] = 32'h12345678;
    @(negedge clk);
    addr = 32'hC; wdata = 64'hCAFEF00D; wstrb = 8'h0F; write = 1'b1; ar[1] = 1'b1;
    @(posedge clk);                        // edge N: write accepted
    @(negedge clk);
    write = 1'b0; wdata = 64'h0;           // second request (read addr 0xC) held
    for (int k = 1; k <= 3; k++) begin
      n_checks++;
      if (busy[1] !== (k <= 3 ? (k != 3) || 1'b1 : 1'b0) || dr[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL wait_busy_%0d: busy=%b dr=%b required busy=1 dr=0", k, busy[1], dr[1]);
      end
      @(posedge clk);
      @(negedge clk);
    end
    n_checks++;
    if (busy[1] !== 1'b0 || dr[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_resp_cycle: busy=%b dr=%b required busy=0 dr=0", busy[1], dr[1]);
    end
    @(posedge clk);                        // edge N+4: response raised, read accepted
    @(negedge clk);
    ar[1] = 1'b0;
    n_checks++;
    if (dr[1] !== 1'b1 || rd1 !== 32'h12345678 || err[1] !== 1'b0 || busy[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_first_resp: dr=%b rdata=%h err=%b busy=%b required 1 12345678 0 1",
               dr[1], rd1, err[1], busy[1]);
    end
    for (int k = 5; k <= 7; k++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (dr[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL wait_gap_%0d: dr=%b required 0", k, dr[1]);
      end
    end
    @(posedge clk);                        // edge N+8
    @(negedge clk);
    n_checks++;
    if (dr[1] !== 1'b1 || rd1 !== 32'hCAFEF00D || err[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_back_resp: dr=%b rdata=%h err=%b required 1 CAFEF00D 0", dr[1], rd1, err[1]);
    end
  endtask

  task automatic test_errors();
    logic [63:0] r; logic e; int lat;
    u0.mem_array.mem[0]  = 32'h5A5A5A5A;
    u0.mem_array.mem[63] = 32'hA5A5A5A5;
    xact(0, 32'h2, 64'h0, 8'h0, 1'b0, r, e, lat);
    n_checks++;
    if (lat !== 1 || e !== 1'b1 || r !== 64'h0) begin
      n_fail++;
      $display("FAIL err_misaligned: lat=%0d err=%b rdata=%h required 1 1 0", lat, e, r);
    end
    xact(0, 32'd256, 64'hFFFFFFFF, 8'h0F, 1'b1, r, e, lat);
    n_checks++;
    if (e !== 1'b1 || r !== 64'h0) begin
      n_fail++;
      $display("FAIL err_oob_write: err=%b rdata=%h required 1 0", e, r);
    end
    xact(0, 32'h0, 64'h0, 8'h0, 1'b0, r, e, lat);
    n_checks++;
    if (r !== 64'h5A5A5A5A || e !== 1'b0) begin
      n_fail++;
      $display("FAIL err_word0_kept: rdata=%h err=%b required 5A5A5A5A 0", r, e);
    end
    xact(0, 32'd252, 64'h0, 8'h0, 1'b0, r, e, lat);
    n_checks++;
    if (r !== 64'hA5A5A5A5 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL err_wordlast_kept: rdata=%h err=%b required A5A5A5A5 0", r, e);
    end
    n_checks++;
    if (busy_seen0 !== 1'b0) begin
      n_fail++;
      $display("FAIL l1_never_busy: busy_seen=%b required 0", busy_seen0);
    end
  endtask

  task automatic test_reset_midop();
    logic [63:0] r; logic e; int lat;
    logic seen;
    u2.mem_array.mem[2] = 32'h01020304;
    @(negedge clk);
    addr = 32'h8; wdata = 64'hFFFFFFFF; wstrb = 8'h0F; write = 1'b1; ar[2] = 1'b1;
    @(posedge clk);                        // edge N
    @(negedge clk);
    ar[2] = 1'b0;
    n_checks++;
    if (busy[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_busy: busy=%b required 1", busy[2]);
    end
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst2_n = 1'b0;
    @(negedge clk);
    rst2_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (dr[2] === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0 || busy[2] !== 1'b0 || err[2] !== 1'b0 || rd2 !== 32'h0) begin
      n_fail++;
      $display("FAIL midop_quiet: dr_seen=%b busy=%b err=%b rdata=%h required all 0", seen, busy[2], err[2], rd2);
    end
    xact(2, 32'h8, 64'h0, 8'h0, 1'b0, r, e, lat);
    n_checks++;
    if (lat !== 8 || r !== 64'h01020304 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_word_kept: lat=%0d rdata=%h err=%b required 8 01020304 0", lat, r, e);
    end
  endtask

  task automatic test_wide();
    logic [63:0] r; logic e; int lat;
    u3.mem_array.mem[1] = 64'h1111111122222222;
    xact(3, 32'h8, 64'hAABBCCDDEEFF0011, 8'hF0, 1'b1, r, e, lat);
    n_checks++;
    if (lat !== 2 || r !== 64'h1111111122222222 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL wide_write_resp: lat=%0d rdata=%h err=%b required 2 1111111122222222 0", lat, r, e);
    end
    xact(3, 32'h8, 64'h0, 8'h0, 1'b0, r, e, lat);
    n_checks++;
    if (r !== 64'hAABBCCDD22222222 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL wide_readback: rdata=%h err=%b required AABBCCDD22222222 0", r, e);
    end
    xact(3, 32'h4, 64'h0, 8'h0, 1'b0, r, e, lat);
    n_checks++;
    if (e !== 1'b1 || r !== 64'h0) begin
      n_fail++;
      $display("FAIL wide_misaligned: err=%b rdata=%h required 1 0", e, r);
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_strobe();
    test_wait_states();
    test_errors();
    test_reset_midop();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wait.md
# mem_wait

Parametrised single-port word RAM with byte-lane write strobes, configurable read/write latency (wait states) and bounds/alignment error reporting. It is the next generation of the testbench/SoC memory model that serves the `rv` core's memory bus (`mem_addr`, `mem_wdata`, `mem_wstrb`, `mem_write`, `mem_addr_ready`, `mem_data_ready`). It lets the core be exercised against slow memories without changing the core-side handshake.

## Interface
- `DATA_W`, 32: data width in bits; multiple of 8, power of two, range 8..128.
- `DEPTH`, 8192: number of `DATA_W`-bit words.
- `LATENCY`, 1: cycles from request acceptance to response; range 1..15.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_addr`  in  32  byte address.
- `mem_wdata`  in  DATA_W  write data.
- `mem_wstrb`  in  DATA_W/8  byte-lane write enables.
- `mem_write`  in  1  1 = write request, 0 = read request.
- `mem_addr_ready`  in  1  request valid.
- `mem_busy`  out  1  request cannot be accepted this cycle.
- `mem_data_ready`  out  1  one-cycle response strobe.
- `mem_rdata`  out  DATA_W  read data, valid while `mem_data_ready` is high.
- `mem_err`  out  1  response is an error, valid while `mem_data_ready` is high.

## Operation
- Define BYTES = DATA_W/8 and OFS = log2(BYTES). Word index = `mem_addr >> OFS`.
- **Accept:** the request is accepted on a rising edge where `mem_addr_ready` is 1 and `mem_busy` is 0. On acceptance, latch addr, wdata, wstrb and write.
- **Busy rule:** a request presented while `mem_busy` is 1 is not accepted. The requester holds it; it is never dropped silently.
- **Error:** raised when the latched address is misaligned (`addr[OFS-1:0] != 0`) or its word index is >= DEPTH.
  - On error, no array write occurs.
  - The response carries `mem_rdata` = 0 and `mem_err` = 1.
- **Read:** `mem_rdata` returns the full word at the index, as it was before any write of the same request (read-before-write).
- **Write:** byte lane b is updated with `wdata[8b+7:8b]` iff `wstrb[b]` = 1; other lanes are unchanged. A write also returns the old word on `mem_rdata`.
- **Array commit:** the array access (read capture and write commit) happens on the edge that raises `mem_data_ready`.
- **State machine (states in `mem_pkg`):**
  - IDLE: on accept, go to RESP if LATENCY = 1, else go to WAIT with cnt = LATENCY-2.
  - WAIT: `mem_busy` = 1; decrement cnt; at cnt = 0, go to RESP.
  - RESP: `mem_data_ready` = 1; `mem_busy` = 0. A new accept in RESP goes to RESP or WAIT as from IDLE; no accept goes to IDLE.
- **Counter width:** 4 bits; never wraps, because it is reloaded only on accept.

## Timing
- **Reset values:** `mem_busy` = 0, `mem_data_ready` = 0, `mem_rdata` = 0, `mem_err` = 0, state IDLE.
- Array contents are not reset.
- **Latency:** accept at edge N, `mem_data_ready` high for exactly one cycle after edge N+LATENCY.
- **Throughput:**
  - LATENCY = 1: one request per cycle, `mem_busy` never asserts; identical to the legacy 1-cycle model.
  - LATENCY = L > 1: one request per L cycles.
- **Back-to-back:** a request accepted in the RESP cycle reads the data written by the response in progress.
- **Reset mid-operation:** asserting `rst_n` low in WAIT aborts the request. No write is committed and no response is issued. After release, the block is IDLE with all outputs 0.
- **Stable inputs:** `mem_addr`, `mem_wdata`, `mem_wstrb` and `mem_write` may change after acceptance without effect.

## Structure
- `mem_pkg`:
  - state enum `mem_state_t` {IDLE, WAIT, RESP};
  - `LAT_CNT_W` = 4;
  - function `mem_ofs(data_w)` returning log2(DATA_W/8).
- Sub-module `mem_array #(DATA_W, DEPTH)`: byte-lane RAM with one synchronous read/write port (index, wstrb, we, wdata, rdata) and no reset. It is also exposed for backdoor preload by benches (`mem_array.mem[i]`).
- Top level holds the FSM, request latch, counter and error check.

## Test plan
- **Reset/preload:** DATA_W = 32, LATENCY = 1. Preload word 0 = 0x11223344 via backdoor; read addr 0 at edge N -> `mem_data_ready` at N+1 with rdata 0x11223344, err 0, busy never 1.
- **Strobed write:** write 0xAABBCCDD, wstrb 4'b0101 to addr 4 over preloaded 0x00000000, then read addr 4 -> 0x00BB00DD. The write response itself returns 0x00000000.
- **Wait states:** LATENCY = 4; read at edge N -> busy 1 for cycles N+1..N+3. A second request held during busy is accepted at edge N+4 (the RESP cycle), and its response arrives at N+8.
- **Errors:** read addr 0x2 -> err 1, rdata 0. Write addr 4*DEPTH -> err 1, and the array is unchanged at index 0 and at DEPTH-1.
- **Reset mid-op:** LATENCY = 8; write 0xFFFFFFFF to addr 8, pull `rst_n` low for 1 cycle at N+3 -> no `mem_data_ready`; word 2 is unchanged; all outputs 0.
- **Wide config:** DATA_W = 64, wstrb 8'hF0, addr 8 -> only bytes 12..15 updated; addr 4 -> err (misaligned).
